// File: rtl/fusion_accum_ctrl.sv
// fusion_accum_ctrl
// Sequences one fusion-unit accumulation job: accepts a job descriptor,
// steps the PE through every bit-pass of every operand pair, waits for the
// PE sum register to settle, then returns the captured sum on a
// valid/ready result port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_valid/cfg_ready   job descriptor handshake (cfg_len, cfg_mode)
//   op_valid/op_ready     operand pair stream; op_ready marks the final pass
//   acc_clr, acc_en       PE accumulator clear / accumulate strobes
//   pass_idx              bit-pass (shift) select for the PE
//   pe_sum                registered PE sum
//   res_valid/res_ready   result handshake, res_data carries the sum
//   busy                  controller not idle
//
// state | meaning
// IDLE  | waiting for a job descriptor
// RUN   | stepping passes/pairs, one accumulate per op_valid beat
// DRAIN | waiting PIPE_LAT cycles for pe_sum to settle
// OUT   | holding the result until res_ready
module fusion_accum_ctrl #(
  parameter int ACC_W    = 20,
  parameter int LEN_W    = 10,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             acc_clr,
  output logic             acc_en,
  output logic [2:0]       pass_idx,
  input  logic [ACC_W-1:0] pe_sum,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [2:0]         pass_last_q, pass_last_d;
  logic [2:0]         pass_cnt_q, pass_cnt_d;
  logic [LEN_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [2:0]         drain_cnt_q, drain_cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;

  logic               last_pass;
  logic               op_hs;
  logic               last_pair;
  logic               drain_done;

  assign last_pass  = (pass_cnt_q == pass_last_q);
  assign op_hs      = (state_q == S_RUN) && op_valid && last_pass;
  assign last_pair  = (pair_cnt_q == len_q - LEN_W'(1));
  assign drain_done = (drain_cnt_q == DRAIN_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pass_last_q <= '0;
      pass_cnt_q  <= '0;
      pair_cnt_q  <= '0;
      drain_cnt_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pass_last_q <= pass_last_d;
      pass_cnt_q  <= pass_cnt_d;
      pair_cnt_q  <= pair_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_valid) state_d = (cfg_len == '0) ? S_OUT : S_RUN;
      S_RUN:   if (op_hs && last_pair) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_OUT;
      S_OUT:   if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters and result register
  always_comb begin
    len_d       = len_q;
    pass_last_d = pass_last_q;
    pass_cnt_d  = pass_cnt_q;
    pair_cnt_d  = pair_cnt_q;
    drain_cnt_d = drain_cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          len_d       = cfg_len;
          // passes-1 kept directly so the wrap compare needs no subtract
          pass_last_d = 3'((4'd1 << cfg_mode) - 4'd1);
          pass_cnt_d  = '0;
          pair_cnt_d  = '0;
          if (cfg_len == '0) begin
            res_data_d  = '0;
            res_valid_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (op_valid) begin
          pass_cnt_d = last_pass ? 3'd0 : pass_cnt_q + 3'd1;
          if (last_pass) begin
            pair_cnt_d = pair_cnt_q + LEN_W'(1);
            if (last_pair) drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (drain_done) begin
          res_data_d  = pe_sum;
          res_valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready) res_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs; strobes are forced low while reset is held
  always_comb begin
    cfg_ready = 1'b0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    op_ready  = 1'b0;
    pass_idx  = 3'd0;
    busy      = 1'b0;
    if (!reset) begin
      cfg_ready = (state_q == S_IDLE);
      acc_clr   = (state_q == S_IDLE) && cfg_valid && (cfg_len != '0);
      acc_en    = (state_q == S_RUN) && op_valid;
      op_ready  = op_hs;
      pass_idx  = pass_cnt_q;
      busy      = (state_q != S_IDLE);
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule
